// File: rtl/add2_bist_pkg.sv
// add2_bist_pkg: shared FSM encoding, CUT widths and default LFSR/MISR feedback masks
package add2_bist_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, CAPTURE = 2'd2, CHECK = 2'd3} bist_state_t;
    localparam int N_IN = 5;
    localparam int N_OUT = 3;
    localparam logic [N_IN-1:0] DEF_LFSR_TAPS = 5'b10100;
    localparam logic [7:0] DEF_MISR_TAPS = 8'b10111000;
endpackage

// File: rtl/add2_bist_ctrl_if.sv
// add2_bist_ctrl_if: test-access and CUT-side signals of the add2 BIST controller
interface add2_bist_ctrl_if #(
    parameter int N_IN  = add2_bist_pkg::N_IN,
    parameter int N_OUT = add2_bist_pkg::N_OUT,
    parameter int SIG_W = 8
);
    logic             start;
    logic             abort;
    logic [N_IN-1:0]  seed;
    logic [SIG_W-1:0] golden_sig;
    logic [N_IN-1:0]  cut_in;
    logic [N_OUT-1:0] cut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [15:0]      pat_idx;
    modport master (output start, abort, seed, golden_sig, cut_out,
                    input cut_in, busy, done, pass, signature, pat_idx);
    modport slave (input start, abort, seed, golden_sig, cut_out,
                   output cut_in, busy, done, pass, signature, pat_idx);
endinterface

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register compacting CUT responses
module bist_misr #(
    parameter int               SIG_W = 8,
    parameter logic [SIG_W-1:0] TAPS  = add2_bist_pkg::DEF_MISR_TAPS,
    parameter int               N_OUT = add2_bist_pkg::N_OUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [N_OUT-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);
    logic [SIG_W-1:0] r_sig;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sig <= '0;
        else if (i_clr) r_sig <= '0;
        else if (i_en) r_sig <= {r_sig[SIG_W-2:0], ^(r_sig & TAPS)} ^ SIG_W'(i_data);
    assign o_sig = r_sig;
endmodule

// File: rtl/add2_bist_ctrl.sv
// add2_bist_ctrl: LFSR pattern sequencer + MISR compaction BIST controller for the add2 CUT
module add2_bist_ctrl #(
    parameter int               N_IN      = add2_bist_pkg::N_IN,
    parameter int               N_OUT     = add2_bist_pkg::N_OUT,
    parameter int               SIG_W     = 8,
    parameter int               PAT_CNT   = 32,
    parameter int               SETTLE    = 1,
    parameter logic [N_IN-1:0]  LFSR_TAPS = add2_bist_pkg::DEF_LFSR_TAPS,
    parameter logic [SIG_W-1:0] MISR_TAPS = add2_bist_pkg::DEF_MISR_TAPS
) (
    input logic             clk,
    input logic             rst_n,
    add2_bist_ctrl_if.slave bus
);
    import add2_bist_pkg::*;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    bist_state_t      r_state;
    logic [N_IN-1:0]  r_lfsr;
    logic [15:0]      r_pat;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [SIG_W-1:0] w_sig;
    logic             w_go;
    logic             w_cap;
    assign w_go  = r_state == IDLE && bus.start && !bus.abort;
    assign w_cap = r_state == CAPTURE && !bus.abort;
    bist_misr #(.SIG_W(SIG_W), .TAPS(MISR_TAPS), .N_OUT(N_OUT)) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_go),
        .i_en  (w_cap),
        .i_data(bus.cut_out),
        .o_sig (w_sig)
    );
    // abort freezes lfsr/misr/pat_idx; only the state and busy flag change
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_lfsr  <= '0;
            r_pat   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (r_state != IDLE && bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_go) begin
                    r_lfsr  <= bus.seed == '0 ? '1 : bus.seed;
                    r_pat   <= '0;
                    r_cnt   <= CW'(SETTLE - 1);
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                    r_state <= APPLY;
                end
                APPLY: if (r_cnt == '0) r_state <= CAPTURE;
                       else r_cnt <= r_cnt - 1'b1;
                CAPTURE: if (r_pat == 16'(PAT_CNT - 1)) r_state <= CHECK;
                         else begin
                             r_lfsr  <= {r_lfsr[N_IN-2:0], ^(r_lfsr & LFSR_TAPS)};
                             r_pat   <= r_pat + 1'b1;
                             r_cnt   <= CW'(SETTLE - 1);
                             r_state <= APPLY;
                         end
                CHECK: begin
                    r_done  <= 1'b1;
                    r_pass  <= w_sig == bus.golden_sig;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    assign bus.cut_in    = r_lfsr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.signature = w_sig;
    assign bus.pat_idx   = r_pat;
endmodule

// File: tb/tb_add2_bist_ctrl.sv
// tb_add2_bist_ctrl: two controllers (4 patterns/zero CUT, 32 patterns/add2 CUT) checked against a cycle-indexed run model
module tb_add2_bist_ctrl;
    localparam int P0 = 4, S0 = 1, P1 = 32, S1 = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    add2_bist_ctrl_if b0 ();
    add2_bist_ctrl_if b1 ();
    add2_bist_ctrl #(.PAT_CNT(P0), .SETTLE(S0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    add2_bist_ctrl #(.PAT_CNT(P1), .SETTLE(S1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // add2 CUT: {N2,N1} + {N4,N3} + N5
    function automatic logic [2:0] add2(input logic [4:0] x);
        return 3'(x[1:0]) + 3'(x[3:2]) + 3'(x[4]);
    endfunction
    assign b0.cut_out = 3'd0;
    assign b1.cut_out = add2(b1.cut_in);

    int npat[2] = '{P0, P1};
    int nset[2] = '{S0, S1};
    int checks = 0, errors = 0;

    function automatic logic [4:0] lfsr_next(input logic [4:0] x);
        return {x[3:0], x[4] ^ x[2]};
    endfunction
    function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [2:0] r);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {5'd0, r};
    endfunction
    function automatic logic [2:0] resp(input int u, input logic [4:0] x);
        return u == 1 ? add2(x) : 3'd0;
    endfunction
    function automatic logic [7:0] final_sig(input int u, input logic [4:0] sd);
        logic [4:0] x = sd == 5'd0 ? 5'h1F : sd;
        logic [7:0] s = 8'd0;
        for (int i = 0; i < npat[u]; i++) begin
            s = misr_next(s, resp(u, x));
            x = lfsr_next(x);
        end
        return s;
    endfunction

    // run model: pattern list and signature-after-i-captures, indexed by cycles since start
    logic [4:0]  pats[2][P1];
    logic [7:0]  sigs[2][P1+1];
    bit          run[2];
    int          k[2];
    logic [4:0]  m_cut[2]  = '{5'd0, 5'd0};
    logic [15:0] m_pat[2]  = '{16'd0, 16'd0};
    logic [7:0]  m_sig[2]  = '{8'd0, 8'd0};
    bit          m_busy[2], m_done[2], m_pass[2];

    task automatic plan(input int u, input logic [4:0] sd);
        pats[u][0] = sd == 5'd0 ? 5'h1F : sd;
        sigs[u][0] = 8'd0;
        for (int i = 0; i < npat[u]; i++) begin
            sigs[u][i+1] = misr_next(sigs[u][i], resp(u, pats[u][i]));
            if (i + 1 < npat[u]) pats[u][i+1] = lfsr_next(pats[u][i]);
        end
    endtask

    task automatic step(input int u, input logic st, input logic ab, input logic [4:0] sd, input logic [7:0] gd);
        int len = npat[u] * (nset[u] + 1);
        int p;
        if (!run[u]) begin
            if (st && !ab) begin
                plan(u, sd);
                run[u] = 1; k[u] = 0;
                m_cut[u] = pats[u][0]; m_pat[u] = 16'd0; m_sig[u] = 8'd0;
                m_busy[u] = 1; m_done[u] = 0; m_pass[u] = 0;
            end
        end else if (ab) begin
            run[u] = 0; m_busy[u] = 0;
        end else begin
            k[u]++;
            if (k[u] < len) begin
                p = k[u] / (nset[u] + 1);
                m_pat[u] = 16'(p); m_cut[u] = pats[u][p]; m_sig[u] = sigs[u][p];
            end else if (k[u] == len) m_sig[u] = sigs[u][npat[u]];
            else begin
                run[u] = 0; m_busy[u] = 0; m_done[u] = 1;
                m_pass[u] = gd == sigs[u][npat[u]];
            end
        end
    endtask

    always @(posedge clk or negedge rst_n)
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                run[u] = 0; k[u] = 0; m_cut[u] = 5'd0; m_pat[u] = 16'd0; m_sig[u] = 8'd0;
                m_busy[u] = 0; m_done[u] = 0; m_pass[u] = 0;
            end else
                step(u, u == 1 ? b1.start : b0.start, u == 1 ? b1.abort : b0.abort,
                     u == 1 ? b1.seed : b0.seed, u == 1 ? b1.golden_sig : b0.golden_sig);
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("u%0d cut_in", u), 32'(u == 1 ? b1.cut_in : b0.cut_in), 32'(m_cut[u]));
            chk($sformatf("u%0d pat_idx", u), 32'(u == 1 ? b1.pat_idx : b0.pat_idx), 32'(m_pat[u]));
            chk($sformatf("u%0d signature", u), 32'(u == 1 ? b1.signature : b0.signature), 32'(m_sig[u]));
            chk($sformatf("u%0d busy", u), 32'(u == 1 ? b1.busy : b0.busy), 32'(m_busy[u]));
            chk($sformatf("u%0d done", u), 32'(u == 1 ? b1.done : b0.done), 32'(m_done[u]));
            chk($sformatf("u%0d pass", u), 32'(u == 1 ? b1.pass : b0.pass), 32'(m_pass[u]));
        end

    // returns at the negedge after the accepting edge E0 (k = 0)
    task automatic go(input int u, input logic [4:0] sd, input logic [7:0] gd);
        @(negedge clk);
        if (u == 0) begin b0.seed = sd; b0.golden_sig = gd; b0.start = 1'b1; end
        else begin b1.seed = sd; b1.golden_sig = gd; b1.start = 1'b1; end
        @(negedge clk);
        b0.start = 1'b0;
        b1.start = 1'b0;
    endtask

    task automatic wait_done(input int u, input int lim, output int n);
        n = 0;
        while (!(u == 1 ? b1.done : b0.done) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("u%0d done within %0d", u, lim), 32'(u == 1 ? b1.done : b0.done), 32'd1);
    endtask

    logic [4:0] lit[4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01001};
    logic [7:0] g;
    int n;

    initial begin
        b0.start = 0; b0.abort = 0; b0.seed = '0; b0.golden_sig = '0;
        b1.start = 0; b1.abort = 0; b1.seed = '0; b1.golden_sig = '0;
        @(negedge clk);
        chk("reset cut_in", 32'(b0.cut_in), 32'd0);
        chk("reset busy", 32'(b0.busy), 32'd0);
        chk("reset done", 32'(b0.done), 32'd0);
        chk("reset pass", 32'(b0.pass), 32'd0);
        chk("reset signature", 32'(b0.signature), 32'd0);
        chk("reset pat_idx", 32'(b1.pat_idx), 32'd0);
        rst_n = 1'b1;
        go(0, 5'b00001, 8'h00);
        for (int kk = 0; kk < 10; kk++) begin
            if (kk < 8) chk($sformatf("T1 cut_in k=%0d", kk), 32'(b0.cut_in), 32'(lit[kk/2]));
            if (kk == 8) chk("T1 done before E0+9", 32'(b0.done), 32'd0);
            if (kk == 9) begin
                chk("T1 done at E0+9", 32'(b0.done), 32'd1);
                chk("T1 pass", 32'(b0.pass), 32'd1);
                chk("T1 signature", 32'(b0.signature), 32'd0);
            end
            if (kk < 9) @(negedge clk);
        end
        go(0, 5'd0, 8'h00);
        chk("T2 first cut_in", 32'(b0.cut_in), 32'h1F);
        repeat (2) @(negedge clk);
        chk("T2 second cut_in", 32'(b0.cut_in), 32'h1E);
        wait_done(0, 20, n);
        g = final_sig(1, 5'h13);
        go(1, 5'h13, g);
        wait_done(1, 200, n);
        chk("T3 latency", 32'(n), 32'(P1 * (S1 + 1) + 1));
        chk("T3 pass", 32'(b1.pass), 32'd1);
        chk("T3 signature", 32'(b1.signature), 32'(g));
        go(1, 5'h13, g ^ 8'h01);
        wait_done(1, 200, n);
        chk("T3 bad golden pass", 32'(b1.pass), 32'd0);
        go(0, 5'b00001, 8'h00);
        repeat (2) @(negedge clk);
        b0.abort = 1'b1;
        @(negedge clk);
        b0.abort = 1'b0;
        chk("T4 abort pat_idx", 32'(b0.pat_idx), 32'd1);
        chk("T4 abort busy", 32'(b0.busy), 32'd0);
        chk("T4 abort done", 32'(b0.done), 32'd0);
        chk("T4 abort pass", 32'(b0.pass), 32'd0);
        go(0, 5'b00001, 8'h00);
        wait_done(0, 20, n);
        chk("T4 rerun pass", 32'(b0.pass), 32'd1);
        go(0, 5'h0B, 8'h00);
        repeat (3) @(negedge clk);
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        wait_done(0, 20, n);
        chk("T5 latency with restart pulse", 32'(n + 4), 32'(P0 * (S0 + 1) + 1));
        go(1, 5'h07, 8'h00);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("T6 async cut_in", 32'(b1.cut_in), 32'd0);
        chk("T6 async busy", 32'(b1.busy), 32'd0);
        chk("T6 async pat_idx", 32'(b1.pat_idx), 32'd0);
        chk("T6 async signature", 32'(b1.signature), 32'd0);
        chk("T6 async done u0", 32'(b0.done), 32'd0);
        chk("T6 async pass u0", 32'(b0.pass), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
